// File: rtl/systolic_pkg.sv
// Shared types for the systolic PE row drain path.
//   ACC_W / DATA_W : accumulator and requantized output widths
//   acc_t / data_t : signed lane value types
//   drain_state_e  : drain controller states
package systolic_pkg;

    localparam int unsigned ACC_W  = 16;
    localparam int unsigned DATA_W = 8;

    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

endpackage : systolic_pkg

// File: rtl/systolic_requant.sv
// Combinational requantizer: signed accumulator -> int8.
// Rounds half up, arithmetic-shifts right by `shift`, then saturates.
// Optional build macro SYSTOLIC_DRAIN_RELU_EN clamps negative results to 0.
// Ports:
//   acc   in  acc_t        accumulator value
//   shift in  [3:0]        right-shift amount, 0..15
//   q     out data_t       requantized result
module systolic_requant
    import systolic_pkg::*;
(
    input  acc_t        acc,
    input  logic [3:0]  shift,
    output data_t       q
);

    // One extra bit so 0x7FFF plus the rounding increment cannot wrap.
    localparam int unsigned EXT_W     = ACC_W + 1;
    localparam int          SAT_MAX_I = (1 << (DATA_W - 1)) - 1;
    localparam int          SAT_MIN_I = -(1 << (DATA_W - 1));
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(SAT_MAX_I);
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(SAT_MIN_I);

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] shifted;
    data_t                   sat;

    // Round, shift, saturate.
    always_comb begin
        ext = {acc[ACC_W-1], acc};
        rnd = '0;
        if (shift != 4'd0) begin
            rnd = EXT_W'(1) << (shift - 4'd1);
        end
        sum     = ext + rnd;
        shifted = sum >>> shift;

        if (shifted > SAT_MAX) begin
            sat = DATA_W'(SAT_MAX_I);
        end else if (shifted < SAT_MIN) begin
            sat = DATA_W'(SAT_MIN_I);
        end else begin
            sat = shifted[DATA_W-1:0];
        end
    end

`ifdef SYSTOLIC_DRAIN_RELU_EN
    // Negative results clamp to zero.
    always_comb begin
        q = sat;
        if (sat[DATA_W-1]) begin
            q = '0;
        end
    end
`else
    always_comb begin
        q = sat;
    end
`endif

endmodule : systolic_requant

// File: rtl/systolic_drain.sv
// Drain stage of the systolic PE row. Snapshots N_LANES accumulators on a
// capture pulse, requantizes each to int8 and streams them out one lane per
// valid/ready transfer, so the PEs can start the next tile immediately.
// Build macro: SYSTOLIC_DRAIN_RELU_EN (negative outputs clamp to 0).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   acc_in      packed accumulators, lane i at [i*ACC_W +: ACC_W]
//   capture     snapshot request pulse
//   shift_amt   right-shift amount, sampled at capture
//   out_data    requantized value of lane out_lane
//   out_lane    lane index currently presented
//   out_valid   out_data/out_lane valid
//   out_ready   downstream accepts
//   busy        snapshot held or draining
//   done        pulse after the last lane is accepted
//   overrun     pulse one cycle after a capture dropped during drain
module systolic_drain #(
    parameter int unsigned N_LANES = 4,
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned DATA_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_LANES*ACC_W-1:0]    acc_in,
    input  logic                        capture,
    input  logic [3:0]                  shift_amt,
    output logic [DATA_W-1:0]           out_data,
    output logic [$clog2(N_LANES)-1:0]  out_lane,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun
);

    localparam int unsigned LANE_W = $clog2(N_LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);

    systolic_pkg::drain_state_e state, state_nxt;

    systolic_pkg::acc_t snap_q [N_LANES];
    logic [3:0]         shift_q;

    logic               accept;
    logic [LANE_W-1:0]  lane_nxt;

    systolic_pkg::acc_t  req_acc;
    logic [3:0]          req_shift;
    systolic_pkg::data_t req_data;

    logic                snap_load;
    logic                valid_d;
    logic                busy_d;
    logic                done_d;
    logic                overrun_d;
    logic [LANE_W-1:0]   lane_d;
    logic [DATA_W-1:0]   data_d;

    assign accept   = out_valid && out_ready;
    assign lane_nxt = out_lane + LANE_W'(1);

    // At capture the first lane is requantized straight from acc_in so it is
    // presented the following cycle; afterwards the snapshot feeds the next lane.
    always_comb begin
        if (state == systolic_pkg::IDLE) begin
            req_acc   = acc_in[ACC_W-1:0];
            req_shift = shift_amt;
        end else begin
            req_acc   = snap_q[lane_nxt];
            req_shift = shift_q;
        end
    end

    systolic_requant u_requant (
        .acc   (req_acc),
        .shift (req_shift),
        .q     (req_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= systolic_pkg::IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            systolic_pkg::IDLE: begin
                if (capture) begin
                    state_nxt = systolic_pkg::DRAIN;
                end
            end
            systolic_pkg::DRAIN: begin
                if (accept && (out_lane == LAST_LANE)) begin
                    state_nxt = systolic_pkg::IDLE;
                end
            end
            default: state_nxt = systolic_pkg::IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        snap_load = 1'b0;
        valid_d   = out_valid;
        busy_d    = busy;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        lane_d    = out_lane;
        data_d    = out_data;
        case (state)
            systolic_pkg::IDLE: begin
                if (capture) begin
                    snap_load = 1'b1;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                    lane_d    = '0;
                    data_d    = req_data;
                end
            end
            systolic_pkg::DRAIN: begin
                // Captures during a drain are dropped, including in the final cycle.
                overrun_d = capture;
                if (accept) begin
                    if (out_lane == LAST_LANE) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        lane_d  = '0;
                        data_d  = '0;
                    end else begin
                        lane_d  = lane_nxt;
                        data_d  = req_data;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            out_lane  <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
            overrun   <= overrun_d;
            out_lane  <= lane_d;
            out_data  <= data_d;
        end
    end

    // Snapshot buffer and shift amount, written only at capture from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_LANES); i++) begin
                snap_q[i] <= '0;
            end
            shift_q <= '0;
        end else if (snap_load) begin
            for (int i = 0; i < int'(N_LANES); i++) begin
                snap_q[i] <= acc_in[i*ACC_W +: ACC_W];
            end
            shift_q <= shift_amt;
        end
    end

endmodule : systolic_drain

// File: tb/tb_systolic_drain.sv
// Self-checking bench for systolic_drain: directed tiles plus randomized
// tiles with random backpressure and stray captures, checked against an
// integer-arithmetic reference of the requantization rule.
module tb_systolic_drain;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int LW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N*AW-1:0]   acc_in;
    logic              capture;
    logic [3:0]        shift_amt;
    logic [DW-1:0]     out_data;
    logic [LW-1:0]     out_lane;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              overrun;

    int n_checks = 0;
    int n_errors = 0;

    systolic_drain #(.N_LANES(N), .ACC_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .acc_in    (acc_in),
        .capture   (capture),
        .shift_amt (shift_amt),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: round half up, floor shift, clamp to int8 (optionally ReLU).
    function automatic int model_q(input int v, input int s);
        int t;
        t = v;
        if (s > 0) t = t + (1 << (s - 1));
        t = t >>> s;
        if (t > 127)  t = 127;
        if (t < -128) t = -128;
`ifdef SYSTOLIC_DRAIN_RELU_EN
        if (t < 0) t = 0;
`endif
        return t;
    endfunction

    function automatic logic [N*AW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [N*AW-1:0] r;
        r[0*AW +: AW] = AW'(a);
        r[1*AW +: AW] = AW'(b);
        r[2*AW +: AW] = AW'(c);
        r[3*AW +: AW] = AW'(d);
        return r;
    endfunction

    function automatic int lane_val(input logic [N*AW-1:0] p, input int i);
        logic signed [AW-1:0] v;
        v = p[i*AW +: AW];
        return int'(v);
    endfunction

    // Capture one tile and drain it, checking every cycle at the negedge.
    task automatic run_tile(input logic [N*AW-1:0] accs, input int sh,
                            input int ready_pct, input int stall_lane, input bit noise);
        int exp_q [N];
        int k, cycles, stall_cnt;
        bit rdy, cap, prev_cap;
        for (int i = 0; i < N; i++) exp_q[i] = model_q(lane_val(accs, i), sh);
        acc_in    = accs;
        shift_amt = 4'(sh);
        capture   = 1'b1;
        @(negedge clk);
        capture   = 1'b0;
        k = 0; cycles = 0; stall_cnt = 0; prev_cap = 1'b0;
        while (k < N && cycles < 200) begin
            check("valid", int'(out_valid), 1);
            check("lane", int'(out_lane), k);
            check("data", int'($signed(out_data)), exp_q[k]);
            check("busy", int'(busy), 1);
            check("done_mid", int'(done), 0);
            check("overrun", int'(overrun), int'(prev_cap));
            if (k == stall_lane && stall_cnt < 5) begin
                rdy = 1'b0;
                stall_cnt++;
            end else begin
                rdy = ($urandom_range(99) < ready_pct);
            end
            cap = noise && (($urandom_range(3) == 0) || (rdy && k == N - 1));
            out_ready = rdy;
            capture   = cap;
            if (cap) begin
                acc_in    = {$urandom, $urandom};
                shift_amt = 4'($urandom_range(15));
            end
            @(negedge clk);
            prev_cap = cap;
            if (rdy) k++;
            cycles++;
        end
        if (k < N) check("timeout", k, N);
        capture   = 1'b0;
        out_ready = 1'b0;
        check("valid_end", int'(out_valid), 0);
        check("done_pulse", int'(done), 1);
        check("busy_end", int'(busy), 0);
        check("overrun_end", int'(overrun), int'(prev_cap));
        @(negedge clk);
        check("done_clr", int'(done), 0);
        check("dropped_cap", int'(out_valid), 0);
        check("overrun_clr", int'(overrun), 0);
    endtask

    // Reset asserted while lane 2 is presented; partial tile is discarded.
    task automatic reset_mid_drain();
        acc_in    = pack4(100, 200, 300, 400);
        shift_amt = 4'd1;
        out_ready = 1'b1;
        capture   = 1'b1;
        @(negedge clk);
        capture   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_lane", int'(out_lane), 2);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_lane", int'(out_lane), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_post_valid", int'(out_valid), 0);
        check("rst_post_done", int'(done), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        acc_in    = '0;
        capture   = 1'b0;
        shift_amt = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_valid", int'(out_valid), 0);
        check("reset_data", int'(out_data), 0);
        check("reset_lane", int'(out_lane), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_tile(pack4(32'h0123, 1000, -5, 0), 2, 100, -1, 1'b0);
        run_tile(pack4(32'h7FFF, -32768, -300, 127), 0, 100, -1, 1'b0);
        run_tile(pack4(32'h7FFF, -32768, 1, -1), 1, 100, -1, 1'b0);
        run_tile(pack4(1000, -1000, 4, -4), 3, 100, -1, 1'b0);
        run_tile(pack4(10, 20, 30, 40), 0, 100, 1, 1'b0);
        run_tile(pack4(500, -500, 7, -9), 2, 100, -1, 1'b1);
        reset_mid_drain();
        run_tile(pack4(64, -64, 255, -255), 4, 100, -1, 1'b0);

        for (int t = 0; t < 25; t++) begin
            logic [N*AW-1:0] r;
            r = {$urandom, $urandom};
            if ($urandom_range(3) == 0) r[0 +: AW] = 16'h7FFF;
            if ($urandom_range(3) == 0) r[AW +: AW] = 16'h8000;
            run_tile(r, int'($urandom_range(15)), 60, int'($urandom_range(N)), 1'($urandom_range(1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_systolic_drain
